vector_list_sequencer: RTL

VECTOR_LIST_SEQUENCER -- requirements
Module: vector_list_sequencer

---
 rtl/vector_list_sequencer_pkg.sv | 26 ++
 rtl/vector_list_sequencer_memory_manage.sv | 32 +++
 rtl/vector_list_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vector_list_sequencer_pkg.sv
// Shared definitions for the vector list sequencer.
// Holds the default widths, the layout of one vector-memory word and the
// sequencer FSM state encoding.
package vector_list_sequencer_pkg;

    localparam int ADDRESSWIDTH_DEF = 10;
    localparam int COORDWIDTH_DEF   = 10;

    // One word of vector memory, MSB first: {x, y, beam_on, last}.
    typedef struct packed {
        logic [COORDWIDTH_DEF-1:0] x;
        logic [COORDWIDTH_DEF-1:0] y;
        logic                      beam_on;
        logic                      last;
    } vec_word_t;

    // Explicit encodings keep the state values stable for older tooling.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/vector_list_sequencer_memory_manage.sv
// Vector-memory address counter: clears on zero, increments on inc.
// Latency: count_adr updates on the clock edge after inc/zero.
// Backpressure: none; the owning FSM decides when to advance.
// Ports: clk, rst (active-high, synchronous), inc, zero, count_adr.
module memory_manage #(
    parameter int ADDRESSWIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inc,
    input  logic                    zero,
    output logic [ADDRESSWIDTH-1:0] count_adr
);

    localparam logic [ADDRESSWIDTH-1:0] ADR_ONE = {{(ADDRESSWIDTH-1){1'b0}}, 1'b1};

    logic [ADDRESSWIDTH-1:0] count_q;

    // zero wins over inc so a fresh frame always starts at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (zero) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + ADR_ONE;
        end
    end

    assign count_adr = count_q;

endmodule

// File: rtl/vector_list_sequencer.sv
// Walks a vector list in synchronous memory and presents each vector to a line drawer.
// Latency: 3 cycles per vector minimum (FETCH, LOAD, PRESENT); frame_done one cycle after the last transfer.
// Backpressure: vector held stable in PRESENT while vec_valid && !vec_ready; traversal stalls.
// Ports: clk, rst (sync, active-low), frame_start, mem_adr/mem_data (memory read),
//        vec_valid/vec_ready/vec_x/vec_y/vec_beam (drawer handshake), busy, frame_done, overrun, wrap_err.
module vector_list_sequencer
    import vector_list_sequencer_pkg::*;
#(
    parameter int ADDRESSWIDTH = ADDRESSWIDTH_DEF,
    parameter int COORDWIDTH   = COORDWIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    output logic [ADDRESSWIDTH-1:0]   mem_adr,
    input  logic [2*COORDWIDTH+1:0]   mem_data,
    output logic                      vec_valid,
    input  logic                      vec_ready,
    output logic [COORDWIDTH-1:0]     vec_x,
    output logic [COORDWIDTH-1:0]     vec_y,
    output logic                      vec_beam,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun,
    output logic                      wrap_err
);

    localparam logic [ADDRESSWIDTH-1:0] ADR_MAX = '1;

    state_e                  state_q, state_d;
    logic [COORDWIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic                    beam_q, beam_d, last_q, last_d;
    logic                    vld_q, vld_d, busy_q, busy_d;
    logic                    done_q, done_d, ovr_q, ovr_d, wrap_q, wrap_d;
    logic                    adr_inc, adr_zero, rst_hi;
    logic [ADDRESSWIDTH-1:0] count_adr;

    assign rst_hi = ~rst;

    memory_manage #(
        .ADDRESSWIDTH(ADDRESSWIDTH)
    ) u_memory_manage (
        .clk      (clk),
        .rst      (rst_hi),
        .inc      (adr_inc),
        .zero     (adr_zero),
        .count_adr(count_adr)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        beam_d   = beam_q;
        last_d   = last_q;
        vld_d    = vld_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        adr_inc  = 1'b0;
        adr_zero = 1'b0;
        // Any start request that IDLE cannot take is flagged, never queued.
        ovr_d    = frame_start && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    adr_zero = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Address is on the bus this cycle; memory answers next cycle.
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                x_d     = mem_data[2*COORDWIDTH+1 -: COORDWIDTH];
                y_d     = mem_data[COORDWIDTH+1 -: COORDWIDTH];
                beam_d  = mem_data[1];
                last_d  = mem_data[0];
                vld_d   = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (vec_ready) begin
                    vld_d = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (count_adr == ADR_MAX) begin
                        // List ran off the end of memory: stop rather than wrap to 0.
                        done_d  = 1'b1;
                        wrap_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        adr_inc = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                vld_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            beam_q  <= 1'b0;
            last_q  <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            beam_q  <= beam_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            wrap_q  <= wrap_d;
        end
    end

    assign mem_adr    = count_adr;
    assign vec_valid  = vld_q;
    assign vec_x      = x_q;
    assign vec_y      = y_q;
    assign vec_beam   = beam_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;
    assign wrap_err   = wrap_q;

endmodule
